// File: rtl/writeback_unit_pkg.sv
// Shared types for the register-file writeback path: data word, register tag, and
// the buffered writeback entry.
package writeback_unit_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  tag_t;

  typedef struct packed {
    tag_t  rd;
    word_t value;
  } wb_entry_t;

endpackage

// File: rtl/writeback_fifo.sv
// Purpose: synchronous FIFO of writeback entries, pointers wrap on a power-of-2 depth.
// Latency: a pushed entry is visible at the head on the next cycle; head read is combinational.
// Backpressure: full/empty flags; a push while full only lands when a pop happens in the same cycle.
module writeback_fifo
  import writeback_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      push,
  input  wb_entry_t push_dat,
  input  logic      pop,
  output wb_entry_t head_dat,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  wb_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            push_ok;
  logic            pop_ok;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign pop_ok   = pop & ~empty;
  assign push_ok  = push & (~full | pop_ok);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// Purpose: merge ALU and load results onto the single register write port, track pending writes. Option: WB_BYPASS_EN.
// Latency: winning result is on valid/rd/rd_value one posedge after it is presented; pending bit clears on that edge.
// Backpressure: ALU never stalled; loads see load_ready low only when the buffer is full and cannot pop this cycle.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int LQ_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic        issue_write,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic        rd_busy,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_value,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [4:0]  load_rd,
  input  logic [31:0] load_value,
`ifdef WB_BYPASS_EN
  output logic        rs1_fwd,
  output logic        rs2_fwd,
  output logic [31:0] rs1_fwd_value,
  output logic [31:0] rs2_fwd_value,
`endif
  output logic        valid,
  output logic        write_rd,
  output logic [4:0]  rd,
  output logic [31:0] rd_value
);

  logic [31:0] pending;
  logic [31:0] pending_nxt;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_push;
  logic        fifo_pop;
  wb_entry_t   fifo_head;
  wb_entry_t   load_entry;
  wb_entry_t   commit;
  logic        commit_vld;
  logic        load_fire;

  assign load_ready = ~fifo_full | (~alu_valid & ~fifo_empty);
  assign load_fire  = load_valid & load_ready;
  assign load_entry = '{rd: load_rd, value: load_value};

  // Priority ALU > buffered load > direct load; a load that loses the port is buffered.
  always_comb begin
    commit     = '{rd: alu_rd, value: alu_value};
    commit_vld = 1'b0;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    if (alu_valid) begin
      commit_vld = 1'b1;
      fifo_push  = load_fire;
    end else if (!fifo_empty) begin
      commit     = fifo_head;
      commit_vld = 1'b1;
      fifo_pop   = 1'b1;
      fifo_push  = load_fire;
    end else if (load_fire) begin
      commit     = load_entry;
      commit_vld = 1'b1;
    end
  end

  writeback_fifo #(.DEPTH(LQ_DEPTH)) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (fifo_push),
    .push_dat (load_entry),
    .pop      (fifo_pop),
    .head_dat (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // A new issue to the same rd on the commit edge keeps the bit set.
  always_comb begin
    pending_nxt = pending;
    if (commit_vld) pending_nxt[commit.rd] = 1'b0;
    if (issue_valid && issue_write && issue_rd != 5'd0) pending_nxt[issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending  <= '0;
      valid    <= 1'b0;
      write_rd <= 1'b0;
      rd       <= '0;
      rd_value <= '0;
    end else begin
      pending  <= pending_nxt;
      valid    <= commit_vld;
      write_rd <= commit_vld & (commit.rd != 5'd0);
      if (commit_vld) begin
        rd       <= commit.rd;
        rd_value <= commit.value;
      end
    end
  end

  assign rd_busy = (issue_rd != 5'd0) & pending[issue_rd];

`ifdef WB_BYPASS_EN
  assign rs1_fwd       = valid & write_rd & (rd == rs1);
  assign rs2_fwd       = valid & write_rd & (rd == rs2);
  assign rs1_fwd_value = rd_value;
  assign rs2_fwd_value = rd_value;
  assign rs1_busy      = (rs1 != 5'd0) & pending[rs1] & ~rs1_fwd;
  assign rs2_busy      = (rs2 != 5'd0) & pending[rs2] & ~rs2_fwd;
`else
  assign rs1_busy      = (rs1 != 5'd0) & pending[rs1];
  assign rs2_busy      = (rs2 != 5'd0) & pending[rs2];
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: arbitration order, load buffering and backpressure,
// pending-write scoreboard, x0 handling, mid-run reset, and optional forwarding.
module tb_writeback_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_write;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        rd_busy;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_value;
  logic        load_valid;
  logic        load_ready;
  logic [4:0]  load_rd;
  logic [31:0] load_value;
  logic        valid;
  logic        write_rd;
  logic [4:0]  rd;
  logic [31:0] rd_value;
`ifdef WB_BYPASS_EN
  logic        rs1_fwd;
  logic        rs2_fwd;
  logic [31:0] rs1_fwd_value;
  logic [31:0] rs2_fwd_value;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  writeback_unit #(.LQ_DEPTH(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_write (issue_write),
    .rs1         (rs1),
    .rs2         (rs2),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .rd_busy     (rd_busy),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_value   (alu_value),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_rd     (load_rd),
    .load_value  (load_value),
`ifdef WB_BYPASS_EN
    .rs1_fwd       (rs1_fwd),
    .rs2_fwd       (rs2_fwd),
    .rs1_fwd_value (rs1_fwd_value),
    .rs2_fwd_value (rs2_fwd_value),
`endif
    .valid       (valid),
    .write_rd    (write_rd),
    .rd          (rd),
    .rd_value    (rd_value)
  );

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_tag(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_commit(input string tag, input logic [4:0] exp_rd, input logic [31:0] exp_val);
    chk_bit({tag, "_valid"}, valid, 1'b1);
    chk_tag({tag, "_rd"}, rd, exp_rd);
    chk_word({tag, "_value"}, rd_value, exp_val);
  endtask

  initial begin
    int li;
    reset       = 1'b1;
    issue_valid = 1'b0;
    issue_rd    = 5'd0;
    issue_write = 1'b0;
    rs1         = 5'd5;
    rs2         = 5'd0;
    alu_valid   = 1'b0;
    alu_rd      = 5'd0;
    alu_value   = 32'd0;
    load_valid  = 1'b0;
    load_rd     = 5'd0;
    load_value  = 32'd0;
    tick();
    tick();
    chk_bit("rst_valid", valid, 1'b0);
    chk_bit("rst_write_rd", write_rd, 1'b0);
    chk_tag("rst_rd", rd, 5'd0);
    chk_word("rst_rd_value", rd_value, 32'd0);
    chk_bit("rst_load_ready", load_ready, 1'b1);
    chk_bit("rst_rs1_busy", rs1_busy, 1'b0);
    reset = 1'b0;
    tick();

    // Issue rd=5, then ALU writes x5 the next cycle.
    issue_valid = 1'b1; issue_rd = 5'd5; issue_write = 1'b1;
    #1 chk_bit("raw_rd_busy_pre", rd_busy, 1'b0);
    tick();
    issue_valid = 1'b0;
    #1 chk_bit("raw_rs1_busy", rs1_busy, 1'b1);
    chk_bit("raw_rd_busy", rd_busy, 1'b1);
    alu_valid = 1'b1; alu_rd = 5'd5; alu_value = 32'h11;
    #1 chk_bit("raw_rs1_busy_commit_cycle", rs1_busy, 1'b1);
    tick();
    alu_valid = 1'b0;
    chk_commit("raw_commit", 5'd5, 32'h11);
    chk_bit("raw_write_rd", write_rd, 1'b1);
    chk_bit("raw_rs1_busy_after", rs1_busy, 1'b0);
    tick();
    chk_bit("idle_valid", valid, 1'b0);
    chk_word("idle_hold_value", rd_value, 32'h11);

    // ALU and load collide: ALU first, load buffered and committed next.
    alu_valid = 1'b1; alu_rd = 5'd3; alu_value = 32'hA;
    load_valid = 1'b1; load_rd = 5'd4; load_value = 32'hB;
    #1 chk_bit("col_load_ready", load_ready, 1'b1);
    tick();
    alu_valid = 1'b0; load_valid = 1'b0;
    chk_commit("col_alu", 5'd3, 32'hA);
    tick();
    chk_commit("col_load", 5'd4, 32'hB);
    tick();
    chk_bit("col_idle", valid, 1'b0);

    // Six ALU cycles with a load offered every cycle: buffer fills after 4 accepts.
    li = 0;
    load_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(20 + i); alu_value = 32'h200 + 32'(i);
      load_rd = 5'(10 + li); load_value = 32'h100 + 32'(li);
      #1 chk_bit($sformatf("fill_ready_%0d", i), load_ready, i < 4);
      tick();
      if (i < 4) li++;
      chk_commit($sformatf("fill_alu_%0d", i), 5'(20 + i), 32'h200 + 32'(i));
    end
    alu_valid = 1'b0;
    load_rd = 5'(10 + li); load_value = 32'h100 + 32'(li);
    #1 chk_bit("drain_ready_pop", load_ready, 1'b1);
    tick();
    load_valid = 1'b0;
    chk_commit("drain_0", 5'd10, 32'h100);
    for (int k = 1; k < 5; k++) begin
      tick();
      chk_commit($sformatf("drain_%0d", k), 5'(10 + k), 32'h100 + 32'(k));
    end
    tick();
    chk_bit("drain_idle", valid, 1'b0);
    chk_bit("drain_ready", load_ready, 1'b1);

    // x0: strobe without write enable, never pending.
    alu_valid = 1'b1; alu_rd = 5'd0; alu_value = 32'h77;
    tick();
    alu_valid = 1'b0;
    chk_bit("x0_alu_valid", valid, 1'b1);
    chk_bit("x0_alu_write_rd", write_rd, 1'b0);
    load_valid = 1'b1; load_rd = 5'd0; load_value = 32'h66;
    tick();
    load_valid = 1'b0;
    chk_bit("x0_load_valid", valid, 1'b1);
    chk_bit("x0_load_write_rd", write_rd, 1'b0);
    chk_word("x0_load_value", rd_value, 32'h66);
    issue_valid = 1'b1; issue_rd = 5'd0; issue_write = 1'b1;
    tick();
    issue_valid = 1'b0;
    rs1 = 5'd0; rs2 = 5'd0;
    #1 chk_bit("x0_rs1_busy", rs1_busy, 1'b0);
    chk_bit("x0_rs2_busy", rs2_busy, 1'b0);
    chk_bit("x0_rd_busy", rd_busy, 1'b0);

    // Issue rd=7 on the edge that commits rd=7: bit stays set.
    issue_valid = 1'b1; issue_rd = 5'd7; issue_write = 1'b1;
    tick();
    alu_valid = 1'b1; alu_rd = 5'd7; alu_value = 32'h70;
    tick();
    issue_valid = 1'b0; alu_valid = 1'b0;
    chk_commit("same_edge_commit", 5'd7, 32'h70);
    tick();
    rs2 = 5'd7;
    #1 chk_bit("same_edge_rs2_busy", rs2_busy, 1'b1);
    alu_valid = 1'b1; alu_rd = 5'd7; alu_value = 32'h71;
    tick();
    alu_valid = 1'b0;
    chk_bit("same_edge_cleared", rs2_busy, 1'b0);

    // Reset with 3 buffered loads and a pending bit.
    issue_valid = 1'b1; issue_rd = 5'd8; issue_write = 1'b1;
    load_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(24 + i); alu_value = 32'h300 + 32'(i);
      load_rd = 5'(1 + i); load_value = 32'h400 + 32'(i);
      tick();
      issue_valid = 1'b0;
    end
    alu_valid = 1'b0; load_valid = 1'b0;
    rs1 = 5'd8;
    #1 chk_bit("prerst_rs1_busy", rs1_busy, 1'b1);
    reset = 1'b1;
    #1 chk_bit("rst_mid_valid", valid, 1'b0);
    chk_bit("rst_mid_rs1_busy", rs1_busy, 1'b0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_bit($sformatf("postrst_no_write_%0d", k), valid, 1'b0);
    end
    chk_bit("postrst_rs1_busy", rs1_busy, 1'b0);
    chk_bit("postrst_load_ready", load_ready, 1'b1);

`ifdef WB_BYPASS_EN
    issue_valid = 1'b1; issue_rd = 5'd9; issue_write = 1'b1;
    tick();
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_value = 32'h55;
    tick();
    alu_valid = 1'b0;
    rs2 = 5'd9;
    #1 chk_bit("fwd_rs2", rs2_fwd, 1'b1);
    chk_word("fwd_rs2_value", rs2_fwd_value, 32'h55);
    chk_bit("fwd_rs2_busy", rs2_busy, 1'b0);
    chk_bit("fwd_rs1_off", rs1_fwd, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
